// File: rtl/pool_stream_layer.sv
// Streaming 2-D pooling layer: FxF non-overlapping windows, stride F, max or
// average, optional ReLU on the input samples. One row buffer entry per
// pooled column holds the running max/sum while a window's rows stream past.
module pool_stream_layer #(
   parameter int I_WIDTH     = 16,
   parameter int CHANNELS    = 5,
   parameter int IMAGE_SIZE  = 254,
   parameter int FILTER_SIZE = 2,
   parameter int MODE        = 0,
   parameter int RELU        = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [CHANNELS*I_WIDTH-1:0]   in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [CHANNELS*I_WIDTH-1:0]   out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          out_last
);

   localparam int OUT_SIZE = IMAGE_SIZE / FILTER_SIZE;
   localparam int LOG2F    = $clog2(FILTER_SIZE);
   localparam int ACC_W    = I_WIDTH + 2*LOG2F;
   localparam int SHIFT    = 2*LOG2F;
   localparam int CW       = $clog2(IMAGE_SIZE + 1);
   localparam int SW       = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
   localparam int IW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
   localparam int DW       = CHANNELS*I_WIDTH;

   // Position is tracked as full coordinate plus (window index, offset in
   // window) so no divider is needed for non-power-of-2 filter sizes.
   logic [CW-1:0] c_q, r_q, c_idx_q, r_idx_q;
   logic [SW-1:0] c_sub_q, r_sub_q;

   logic          accept, col_end, row_end, in_region, first, complete, is_last;
   logic [IW-1:0] buf_idx;
   logic [DW-1:0] res_w;

   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign col_end   = (c_q == CW'(IMAGE_SIZE-1));
   assign row_end   = (r_q == CW'(IMAGE_SIZE-1));
   assign in_region = (c_idx_q < CW'(OUT_SIZE)) && (r_idx_q < CW'(OUT_SIZE));
   assign first     = (c_sub_q == '0) && (r_sub_q == '0);
   assign complete  = in_region && (c_sub_q == SW'(FILTER_SIZE-1))
                                && (r_sub_q == SW'(FILTER_SIZE-1));
   assign is_last   = (c_idx_q == CW'(OUT_SIZE-1)) && (r_idx_q == CW'(OUT_SIZE-1));
   assign buf_idx   = c_idx_q[IW-1:0];

   // Raster position counters, advanced once per accepted pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q     <= '0;
         r_q     <= '0;
         c_idx_q <= '0;
         r_idx_q <= '0;
         c_sub_q <= '0;
         r_sub_q <= '0;
      end else if (accept) begin
         if (col_end) begin
            c_q     <= '0;
            c_idx_q <= '0;
            c_sub_q <= '0;
            if (row_end) begin
               r_q     <= '0;
               r_idx_q <= '0;
               r_sub_q <= '0;
            end else begin
               r_q <= r_q + CW'(1);
               if (r_sub_q == SW'(FILTER_SIZE-1)) begin
                  r_sub_q <= '0;
                  r_idx_q <= r_idx_q + CW'(1);
               end else begin
                  r_sub_q <= r_sub_q + SW'(1);
               end
            end
         end else begin
            c_q <= c_q + CW'(1);
            if (c_sub_q == SW'(FILTER_SIZE-1)) begin
               c_sub_q <= '0;
               c_idx_q <= c_idx_q + CW'(1);
            end else begin
               c_sub_q <= c_sub_q + SW'(1);
            end
         end
      end
   end

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
      logic signed [I_WIDTH-1:0] raw;
      logic signed [ACC_W-1:0]   samp, prev, comb, avg;
      logic signed [ACC_W-1:0]   rowbuf_q [OUT_SIZE];

      assign raw  = in_data[ch*I_WIDTH +: I_WIDTH];
      assign samp = (RELU != 0 && raw[I_WIDTH-1]) ? '0 : ACC_W'(raw);
      assign prev = rowbuf_q[buf_idx];

      // Window-first pixel overwrites the entry, so stale data never needs clearing.
      always_comb begin
         comb = samp;
         if (!first) begin
            if (MODE == 1) comb = prev + samp;
            else           comb = (samp > prev) ? samp : prev;
         end
      end

      assign avg = comb >>> SHIFT;
      assign res_w[ch*I_WIDTH +: I_WIDTH] = (MODE == 1) ? I_WIDTH'(avg) : I_WIDTH'(comb);

      // Row buffer update; contents are don't-care after reset.
      always_ff @(posedge clk) begin
         if (accept && in_region) rowbuf_q[buf_idx] <= comb;
      end
   end

   // Single output register: load on window completion, drop only when consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (accept && complete) begin
         out_data  <= res_w;
         out_valid <= 1'b1;
         out_last  <= is_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pool_stream_layer.sv
// Bench for pool_stream_layer: five small instances (max, average, ReLU,
// odd frame size, F=1) share clock, reset and pixel bus; each has its own
// valid/ready so one instance is exercised at a time.
module tb_pool_stream_layer;

   localparam int BUDGET = 100;
   localparam int NV     = 7;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [7:0]       in_data;
   logic [4:0]       iv;
   logic [4:0]       ordy;
   logic [4:0]       irdy;
   logic [4:0]       ov;
   logic [4:0]       ol;
   logic [4:0][7:0]  od;

   int               checks = 0;
   int               errors = 0;
   int               sel = 0;
   logic [8:0]       recq [$];

   typedef struct {
      int              dut;
      int              npix;
      logic [7:0]      base;
      logic [7:0]      step;
      int              nexp;
      logic [3:0][7:0] exp;
   } vec_t;

   vec_t vecs [NV];

   always #5 clk = ~clk;

   pool_stream_layer #(.I_WIDTH(8), .CHANNELS(1), .IMAGE_SIZE(4), .FILTER_SIZE(2), .MODE(0), .RELU(0)) u_max (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(iv[0]), .in_ready(irdy[0]),
      .out_data(od[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_last(ol[0]));
   pool_stream_layer #(.I_WIDTH(8), .CHANNELS(1), .IMAGE_SIZE(4), .FILTER_SIZE(2), .MODE(1), .RELU(0)) u_avg (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(iv[1]), .in_ready(irdy[1]),
      .out_data(od[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_last(ol[1]));
   pool_stream_layer #(.I_WIDTH(8), .CHANNELS(1), .IMAGE_SIZE(4), .FILTER_SIZE(2), .MODE(0), .RELU(1)) u_relu (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(iv[2]), .in_ready(irdy[2]),
      .out_data(od[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_last(ol[2]));
   pool_stream_layer #(.I_WIDTH(8), .CHANNELS(1), .IMAGE_SIZE(5), .FILTER_SIZE(2), .MODE(0), .RELU(0)) u_odd (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(iv[3]), .in_ready(irdy[3]),
      .out_data(od[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_last(ol[3]));
   pool_stream_layer #(.I_WIDTH(8), .CHANNELS(1), .IMAGE_SIZE(2), .FILTER_SIZE(1), .MODE(0), .RELU(1)) u_f1 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(iv[4]), .in_ready(irdy[4]),
      .out_data(od[4]), .out_valid(ov[4]), .out_ready(ordy[4]), .out_last(ol[4]));

   // Record every consumed output of the selected instance as {last, data}.
   always @(negedge clk) begin
      if (rst_n && ov[sel] && ordy[sel]) recq.push_back({ol[sel], od[sel]});
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Present n pixels base, base+step, ... to instance k, waiting for acceptance.
   task automatic stream(input int k, input int n, input logic [7:0] base, input logic [7:0] step);
      for (int i = 0; i < n; i++) begin
         bit done;
         int b;
         done = 1'b0;
         b = 0;
         in_data = base + step * 8'(i);
         iv[k] = 1'b1;
         while (!done && b < BUDGET) begin
            @(negedge clk);
            if (irdy[k]) begin
               @(posedge clk);
               #1;
               done = 1'b1;
            end
            b++;
         end
         if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: dut %0d pixel %0d not accepted in %0d cycles", k, i, BUDGET);
         end
      end
      iv[k] = 1'b0;
   endtask

   task automatic check_queue(input string nm, input int nexp, input logic [3:0][7:0] exp);
      chk($sformatf("%s_count", nm), 32'(recq.size()), 32'(nexp));
      for (int j = 0; j < nexp; j++) begin
         if (j < recq.size()) begin
            chk($sformatf("%s_data%0d", nm, j), 32'(recq[j][7:0]), 32'(exp[j]));
            chk($sformatf("%s_last%0d", nm, j), 32'(recq[j][8]), 32'(j == nexp-1));
         end
      end
   endtask

   initial begin
      vecs[0] = '{0, 16, 8'h00, 8'h01, 4, {8'd15, 8'd13, 8'd7,  8'd5}};
      vecs[1] = '{1, 16, 8'h00, 8'h01, 4, {8'd12, 8'd10, 8'd4,  8'd2}};
      vecs[2] = '{2, 16, 8'hFD, 8'h00, 4, {8'h00, 8'h00, 8'h00, 8'h00}};
      vecs[3] = '{0, 16, 8'hFD, 8'h00, 4, {8'hFD, 8'hFD, 8'hFD, 8'hFD}};
      vecs[4] = '{3, 25, 8'h00, 8'h01, 4, {8'd18, 8'd16, 8'd8,  8'd6}};
      vecs[5] = '{3, 25, 8'h00, 8'h01, 4, {8'd18, 8'd16, 8'd8,  8'd6}};
      vecs[6] = '{4, 4,  8'hFF, 8'h02, 4, {8'h05, 8'h03, 8'h01, 8'h00}};

      rst_n   = 1'b0;
      in_data = 8'h00;
      iv      = '0;
      ordy    = '1;
      #12;
      chk("rst_out_valid", 32'(ov[0]), 32'd0);
      chk("rst_out_last",  32'(ol[0]), 32'd0);
      chk("rst_out_data",  32'(od[0]), 32'd0);
      chk("rst_in_ready",  32'(irdy[0]), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         sel = vecs[i].dut;
         recq.delete();
         stream(vecs[i].dut, vecs[i].npix, vecs[i].base, vecs[i].step);
         repeat (4) @(posedge clk);
         #1;
         check_queue($sformatf("vec%0d", i), vecs[i].nexp, vecs[i].exp);
      end

      // Backpressure: first output held while out_ready is low.
      sel = 0;
      recq.delete();
      ordy[0] = 1'b0;
      fork
         stream(0, 16, 8'h00, 8'h01);
         begin
            int b;
            b = 0;
            @(negedge clk);
            while (!ov[0] && b < BUDGET) begin
               @(negedge clk);
               b++;
            end
            chk("bp_valid_seen", 32'(ov[0]), 32'd1);
            for (int k = 0; k < 6; k++) begin
               chk($sformatf("bp_hold_data%0d", k),  32'(od[0]),   32'd5);
               chk($sformatf("bp_hold_valid%0d", k), 32'(ov[0]),   32'd1);
               chk($sformatf("bp_hold_ready%0d", k), 32'(irdy[0]), 32'd0);
               @(negedge clk);
            end
            @(posedge clk);
            #1;
            ordy[0] = 1'b1;
            @(negedge clk);
            chk("bp_ready_after", 32'(irdy[0]), 32'd1);
         end
      join
      repeat (4) @(posedge clk);
      #1;
      check_queue("bp", 4, {8'd15, 8'd13, 8'd7, 8'd5});

      // Reset in the middle of a frame, asserted between clock edges.
      sel = 0;
      stream(0, 6, 8'h40, 8'h01);
      chk("mid_valid_before_rst", 32'(ov[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_async_valid", 32'(ov[0]), 32'd0);
      chk("mid_async_data",  32'(od[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      recq.delete();
      stream(0, 16, 8'h00, 8'h01);
      repeat (4) @(posedge clk);
      #1;
      check_queue("mid", 4, {8'd15, 8'd13, 8'd7, 8'd5});

      // F=1: a single pixel appears on the output one cycle after acceptance.
      sel = 4;
      stream(4, 1, 8'h7F, 8'h00);
      chk("f1_latency_valid", 32'(ov[4]), 32'd1);
      chk("f1_latency_data",  32'(od[4]), 32'h7F);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
